// File: rtl/bnn_pkg.sv
// Shared types and helpers for the sequential binary neuron.
package bnn_pkg;

    // Evaluation sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Synapse modes selected by the XNOR_MODE parameter.
    localparam int MODE_AND  = 0;
    localparam int MODE_XNOR = 1;

    // Accumulator width that can hold any popcount 0..n_inputs.
    function automatic int acc_bits(input int n_inputs);
        return $clog2(n_inputs + 1);
    endfunction

endpackage

// File: rtl/bnn_popcount.sv
// Combinational population count of one synapse chunk.
module bnn_popcount #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0]             bits_in,
    output logic [$clog2(WIDTH+1)-1:0]   count
);

    localparam int CW = $clog2(WIDTH + 1);

    // Sum the set bits of the chunk.
    always_comb begin
        // NOTE: assigning a default before the loop keeps this purely
        // combinational; a path that skips the assignment would infer a latch.
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + CW'(bits_in[i]);
        end
    end

endmodule

// File: rtl/bnn_neuron_seq.sv
// Time-multiplexed binary neuron: serial weight/bias chain, LANES synapses
// per cycle, registered axon with a one-cycle valid pulse.
// Optional macro BNN_NEURON_ACC_OUT_EN adds the acc_out port holding the
// final popcount of the last evaluation.
module bnn_neuron_seq
    import bnn_pkg::*;
#(
    parameter int INPUTS         = 8,
    parameter int LANES          = 2,
    parameter int BIAS_BITS      = 3,
    parameter int XNOR_MODE      = 0,
    parameter int USE_CHEAP_BIAS = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              setup,
    input  logic              param_in,
    output logic              param_out,
    input  logic              start,
    input  logic [INPUTS-1:0] inputs,
    output logic              busy,
    output logic              axon,
    output logic              axon_valid
`ifdef BNN_NEURON_ACC_OUT_EN
    ,
    output logic [acc_bits(INPUTS)-1:0] acc_out
`endif
);

    localparam int ACC_BITS = acc_bits(INPUTS);
    localparam int NCHUNK   = INPUTS / LANES;
    localparam int CNT_BITS = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PC_BITS  = $clog2(LANES + 1);
    localparam int CMP_BITS = (ACC_BITS > BIAS_BITS) ? ACC_BITS : BIAS_BITS;
    localparam logic [CNT_BITS-1:0] LAST_CHUNK = CNT_BITS'(NCHUNK - 1);

    state_e                state_q,   state_d;
    logic [INPUTS-1:0]     weights_q, weights_d;
    logic [BIAS_BITS-1:0]  bias_q,    bias_d;
    logic [ACC_BITS-1:0]   acc_q,     acc_d;
    logic [CNT_BITS-1:0]   cnt_q,     cnt_d;
    logic [INPUTS-1:0]     in_q,      in_d;
    logic                  axon_q,    axon_d;
    logic                  valid_q,   valid_d;
`ifdef BNN_NEURON_ACC_OUT_EN
    logic [ACC_BITS-1:0]   acc_out_q, acc_out_d;
`endif

    logic [INPUTS-1:0]     syn_all;
    logic [LANES-1:0]      syn_chunk;
    logic [PC_BITS-1:0]    chunk_count;
    logic [ACC_BITS-1:0]   acc_sum;
    logic [CMP_BITS-1:0]   acc_ext;
    logic [CMP_BITS-1:0]   bias_ext;
    logic                  fire;

    // Synapse vector for the latched activations and the current chunk.
    always_comb begin
        if (XNOR_MODE == MODE_XNOR) begin
            syn_all = ~(weights_q ^ in_q);
        end else begin
            syn_all = weights_q & in_q;
        end
        syn_chunk = syn_all[cnt_q*LANES +: LANES];
    end

    bnn_popcount #(
        .WIDTH (LANES)
    ) u_popcount (
        .bits_in (syn_chunk),
        .count   (chunk_count)
    );

    // Running sum including this cycle's chunk, and the threshold decision on it.
    always_comb begin
        acc_sum  = acc_q + ACC_BITS'(chunk_count);
        acc_ext  = CMP_BITS'(acc_sum);
        bias_ext = CMP_BITS'(bias_q);
        if (USE_CHEAP_BIAS != 0) begin
            fire = |(acc_ext & bias_ext);
        end else begin
            fire = (acc_ext > bias_ext);
        end
    end

    // Next-state logic for the sequencer, parameter chain and datapath.
    always_comb begin
        state_d   = state_q;
        weights_d = weights_q;
        bias_d    = bias_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        in_d      = in_q;
        axon_d    = axon_q;
        valid_d   = 1'b0;
`ifdef BNN_NEURON_ACC_OUT_EN
        acc_out_d = acc_out_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (setup) begin
                    // Chain: param_in -> weights[0..INPUTS-1] -> bias[0..BIAS_BITS-1].
                    bias_d    = (bias_q << 1) | BIAS_BITS'(weights_q[INPUTS-1]);
                    weights_d = (weights_q << 1) | INPUTS'(param_in);
                end else if (start) begin
                    in_d    = inputs;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CHUNK) begin
                    // Register the decision now so it is visible during DONE.
                    cnt_d   = '0;
                    axon_d  = fire;
                    valid_d = 1'b1;
`ifdef BNN_NEURON_ACC_OUT_EN
                    acc_out_d = acc_sum;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                // setup is ignored here; start gives back-to-back evaluation.
                if (start) begin
                    in_d    = inputs;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: the parameter chain is reset too; a reset neuron must read
            // back as all-zero weights and bias, not keep stale contents.
            state_q   <= IDLE;
            weights_q <= '0;
            bias_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            in_q      <= '0;
            axon_q    <= 1'b0;
            valid_q   <= 1'b0;
`ifdef BNN_NEURON_ACC_OUT_EN
            acc_out_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            weights_q <= weights_d;
            bias_q    <= bias_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            in_q      <= in_d;
            axon_q    <= axon_d;
            valid_q   <= valid_d;
`ifdef BNN_NEURON_ACC_OUT_EN
            acc_out_q <= acc_out_d;
`endif
        end
    end

    // Outputs come straight from registers; param_out adds no latency.
    always_comb begin
        busy       = (state_q == ACCUM);
        param_out  = bias_q[BIAS_BITS-1];
        axon       = axon_q;
        axon_valid = valid_q;
`ifdef BNN_NEURON_ACC_OUT_EN
        acc_out    = acc_out_q;
`endif
    end

endmodule
